// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM requesters.
// Out-of-range accesses are trapped, flagged in err_status and never reach the RAM.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int DEPTH  = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [1:0]        err_status,
  input  logic              err_clear
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic              req0, req1;
  logic              grant0, grant1, granted;
  logic [ADDR_W-1:0] g_address;
  logic [BE_W-1:0]   g_byteenable;
  logic [DATA_W-1:0] g_writedata;
  logic              g_write, g_read, in_range;
  logic [1:0]        err_set;
  logic [DATA_W-1:0] rd_data;

  logic last_grant;
  logic rd_valid, rd_port, rd_oob;

  // Grants are suppressed while reset is asserted so nothing is accepted.
  always_comb begin
    req0    = p0_read | p0_write;
    req1    = p1_read | p1_write;
    grant0  = reset_n & req0 & (~req1 | last_grant);
    grant1  = reset_n & req1 & (~req0 | ~last_grant);
    granted = grant0 | grant1;

    g_address    = grant1 ? p1_address    : p0_address;
    g_byteenable = grant1 ? p1_byteenable : p0_byteenable;
    g_writedata  = grant1 ? p1_writedata  : p0_writedata;
    g_write      = grant1 ? p1_write      : p0_write;
    g_read       = grant1 ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
    in_range     = {1'b0, g_address} < DEPTH_LIM;

    mem_chipselect = granted & in_range;
    mem_write      = granted & in_range & g_write;
    mem_address    = g_address;
    mem_byteenable = g_byteenable;
    mem_writedata  = g_writedata;

    p0_waitrequest = ~reset_n | (req0 & ~grant0);
    p1_waitrequest = ~reset_n | (req1 & ~grant1);

    err_set = {grant1 & ~in_range, grant0 & ~in_range};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_port    <= 1'b0;
      rd_oob     <= 1'b1;
      err_status <= 2'b00;
    end else begin
      if (granted) begin
        last_grant <= grant1;
        rd_port    <= grant1;
        rd_oob     <= ~in_range;
      end
      rd_valid   <= granted & g_read;
      // A new trap in the same cycle as err_clear must survive.
      err_status <= (err_clear ? 2'b00 : err_status) | err_set;
    end
  end

  // The reset_n term drops a response whose read was accepted just before reset.
  always_comb begin
    rd_data          = rd_oob ? '0 : mem_readdata;
    p0_readdata      = rd_data;
    p1_readdata      = rd_data;
    p0_readdatavalid = reset_n & rd_valid & ~rd_port;
    p1_readdatavalid = reset_n & rd_valid & rd_port;
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural one-cycle-latency RAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [16:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic [1:0]  err_status;
  logic        err_clear;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable),
    .p0_read(p0_read), .p0_write(p0_write), .p0_writedata(p0_writedata),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
    .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable),
    .p1_read(p1_read), .p1_write(p1_write), .p1_writedata(p1_writedata),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
    .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .err_status(err_status), .err_clear(err_clear)
  );

  // RAM model: byte-lane writes, registered read.
  logic [31:0] ram [0:(1<<17)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("  ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input int p, input logic r, input logic w, input logic [16:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      p0_read = r; p0_write = w; p0_address = a; p0_byteenable = be; p0_writedata = d;
    end else begin
      p1_read = r; p1_write = w; p1_address = a; p1_byteenable = be; p1_writedata = d;
    end
  endtask

  task automatic idle();
    req(0, 1'b0, 1'b0, 17'h0, 4'h0, 32'h0);
    req(1, 1'b0, 1'b0, 17'h0, 4'h0, 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    err_clear = 1'b0;
    idle();
    @(negedge clk);
    tick();
    #1;
    chk("rst_wait0", 32'(p0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(p1_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_rdv0", 32'(p0_readdatavalid), 32'd0);
    chk("rst_rdv1", 32'(p1_readdatavalid), 32'd0);
    chk("rst_err", 32'(err_status), 32'd0);
    chk("rst_rdata", p0_readdata, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("idle_wait0", 32'(p0_waitrequest), 32'd0);

    // Preload words 1 and 2 through the arbiter, then reset again.
    $display("txn: preload ram[1], ram[2]");
    req(0, 1'b0, 1'b1, 17'h1, 4'hF, 32'h11111111);
    tick();
    idle();
    req(1, 1'b0, 1'b1, 17'h2, 4'hF, 32'h22222222);
    tick();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Continuous contention: grants alternate starting with port 0.
    $display("txn: both ports read continuously");
    req(0, 1'b1, 1'b0, 17'h1, 4'hF, 32'h0);
    req(1, 1'b1, 1'b0, 17'h2, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_wait0", i), 32'(p0_waitrequest), 32'(i % 2 != 0));
      chk($sformatf("rr%0d_wait1", i), 32'(p1_waitrequest), 32'(i % 2 != 1));
      chk($sformatf("rr%0d_addr", i), 32'(mem_address), (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i > 0) begin
        chk($sformatf("rr%0d_rdv0", i), 32'(p0_readdatavalid), 32'((i - 1) % 2 == 0));
        chk($sformatf("rr%0d_rdv1", i), 32'(p1_readdatavalid), 32'((i - 1) % 2 == 1));
        chk($sformatf("rr%0d_rdata", i), p0_readdata,
            ((i - 1) % 2 == 1) ? 32'h22222222 : 32'h11111111);
      end
      tick();
    end
    idle();
    #1;
    chk("rr_last_rdv1", 32'(p1_readdatavalid), 32'd1);
    chk("rr_last_rdata", p1_readdata, 32'h22222222);
    tick();

    $display("txn: p0 write 0xCAFEBABE @0x10 then read");
    req(0, 1'b0, 1'b1, 17'h10, 4'hF, 32'hCAFEBABE);
    #1;
    chk("w0_wait0", 32'(p0_waitrequest), 32'd0);
    chk("w0_cs", 32'(mem_chipselect), 32'd1);
    chk("w0_mwrite", 32'(mem_write), 32'd1);
    chk("w0_maddr", 32'(mem_address), 32'h10);
    chk("w0_mwdata", mem_writedata, 32'hCAFEBABE);
    tick();
    req(0, 1'b1, 1'b0, 17'h10, 4'hF, 32'h0);
    #1;
    chk("r0_wait0", 32'(p0_waitrequest), 32'd0);
    chk("r0_cs", 32'(mem_chipselect), 32'd1);
    chk("r0_mwrite", 32'(mem_write), 32'd0);
    tick();
    idle();
    #1;
    chk("r0_rdv0", 32'(p0_readdatavalid), 32'd1);
    chk("r0_rdata", p0_readdata, 32'hCAFEBABE);
    chk("r0_rdv1", 32'(p1_readdatavalid), 32'd0);
    tick();
    #1;
    chk("r0_rdv0_once", 32'(p0_readdatavalid), 32'd0);

    $display("txn: p1 byte-lane write over 0x11223344");
    req(1, 1'b0, 1'b1, 17'h20, 4'hF, 32'h11223344);
    #1;
    chk("w1_wait1", 32'(p1_waitrequest), 32'd0);
    tick();
    req(1, 1'b0, 1'b1, 17'h20, 4'h2, 32'h0000AB00);
    #1;
    chk("w1_be", 32'(mem_byteenable), 32'h2);
    tick();
    req(1, 1'b1, 1'b0, 17'h20, 4'hF, 32'h0);
    tick();
    idle();
    #1;
    chk("r1_rdv1", 32'(p1_readdatavalid), 32'd1);
    chk("r1_rdata", p1_readdata, 32'h1122AB44);
    chk("r1_rdv0", 32'(p0_readdatavalid), 32'd0);
    tick();

    $display("txn: p0 out-of-range read @100000");
    req(0, 1'b1, 1'b0, 17'd100000, 4'hF, 32'h0);
    #1;
    chk("oob_cs", 32'(mem_chipselect), 32'd0);
    chk("oob_wait0", 32'(p0_waitrequest), 32'd0);
    tick();
    idle();
    #1;
    chk("oob_rdv0", 32'(p0_readdatavalid), 32'd1);
    chk("oob_rdata", p0_readdata, 32'h0);
    chk("oob_err", 32'(err_status), 32'h1);

    $display("txn: err_clear with new out-of-range write");
    req(0, 1'b0, 1'b1, 17'h1FFFF, 4'hF, 32'hDEADBEEF);
    err_clear = 1'b1;
    #1;
    chk("oobw_cs", 32'(mem_chipselect), 32'd0);
    chk("oobw_mwrite", 32'(mem_write), 32'd0);
    tick();
    err_clear = 1'b0;
    idle();
    #1;
    chk("setwins_err", 32'(err_status), 32'h1);
    chk("oobw_rdv0", 32'(p0_readdatavalid), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1;
    chk("clear_err", 32'(err_status), 32'h0);
    req(1, 1'b0, 1'b1, 17'd100001, 4'hF, 32'h0);
    tick();
    idle();
    #1;
    chk("oob1_err", 32'(err_status), 32'h2);

    $display("txn: p1 read then reset");
    req(1, 1'b1, 1'b0, 17'h2, 4'hF, 32'h0);
    #1;
    chk("rr1_wait1", 32'(p1_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req(0, 1'b1, 1'b0, 17'h1, 4'hF, 32'h0);
    req(1, 1'b1, 1'b0, 17'h2, 4'hF, 32'h0);
    @(negedge clk);
    chk("mrst_rdv1", 32'(p1_readdatavalid), 32'd0);
    chk("mrst_wait0", 32'(p0_waitrequest), 32'd1);
    chk("mrst_wait1", 32'(p1_waitrequest), 32'd1);
    chk("mrst_cs", 32'(mem_chipselect), 32'd0);
    tick();
    #1;
    chk("mrst_rdv1_b", 32'(p1_readdatavalid), 32'd0);
    chk("mrst_err", 32'(err_status), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("post_wait0", 32'(p0_waitrequest), 32'd0);
    chk("post_wait1", 32'(p1_waitrequest), 32'd1);
    chk("post_cs", 32'(mem_chipselect), 32'd1);
    chk("post_maddr", 32'(mem_address), 32'h1);
    tick();
    idle();
    #1;
    chk("post_rdv0", 32'(p0_readdatavalid), 32'd1);
    chk("post_rdata", p0_readdata, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip RAM between the Nios II data master (port 0) and the audio sample capture engine (port 1). Each requester sees an Avalon-MM slave with waitrequest and readdatavalid. The block drives the RAM's chipselect/write/address/byteenable side and routes the RAM's one-cycle-latency readdata back to the requester that issued the read. Out-of-range accesses are trapped and never reach the RAM.

## Interface
- ADDR_W, 17, word address width (both ports and RAM)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- DEPTH, 100000, number of valid RAM words; addresses >= DEPTH are out of range
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- pN_address  in  ADDR_W  word address, port N (N = 0, 1)
- pN_byteenable  in  BE_W  byte lanes for writes
- pN_read / pN_write  in  1  request strobes; both high at once is treated as write
- pN_writedata  in  DATA_W  write data
- pN_waitrequest  out  1  request not accepted this cycle; master holds all inputs
- pN_readdata  out  DATA_W  read data, valid only with pN_readdatavalid
- pN_readdatavalid  out  1  one-cycle pulse per accepted read
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_readdata  in  DATA_W  from RAM; valid one cycle after address presented
- err_status  out  2  sticky out-of-range flag, bit N for port N
- err_clear  in  1  single-cycle pulse clears err_status

## Operation
- reqN = pN_read | pN_write. One access is granted per cycle, with no idle cycle required between grants.
- Arbitration:
  - Only one req: that port is granted.
  - Both req: grant goes to the port not recorded in the last_grant register.
  - last_grant updates only on cycles where a grant occurs.
  - Reset value of last_grant = 1, so port 0 wins the first tie.
- Granted port: pN_waitrequest = 0 combinationally in the same cycle.
- Non-granted requesting port: pN_waitrequest = 1.
- Idle port (no req): waitrequest = 0. This is a don't-care per Avalon, but it is fixed at 0 for verification.
- Granted in-range access (address < DEPTH):
  - mem_chipselect = 1.
  - mem_write = pN_write.
  - mem_address, mem_byteenable, mem_writedata are muxed from the granted port.
- Granted out-of-range access:
  - mem_chipselect = 0 and mem_write = 0; no RAM access.
  - err_status[N] is set on the next edge.
  - A read still completes, with readdata = 0.
- No grant: mem_chipselect = 0, mem_write = 0. The address/data mux still follows port 0 (don't-care).
- Read return pipeline: one stage of registers {rd_valid, rd_port, rd_oob}, loaded on the grant cycle.
  - Cycle after grant: pN_readdatavalid = 1 for rd_port only.
  - pN_readdata = rd_oob ? 0 : mem_readdata.
  - pN_readdata is driven to both ports at all times; consumers qualify it with readdatavalid.
- Writes produce no response beyond waitrequest deasserting.
- err_status: set and clear in the same cycle → set wins.
- Reset (reset_n low at a clock edge), including mid-operation:
  - last_grant := 1, rd_valid := 0, err_status := 0.
  - A read accepted in the cycle before reset produces no readdatavalid.
  - While reset_n is low: both waitrequest = 1 and mem_chipselect = 0 combinationally, so nothing is accepted.

## Timing
- Read latency: exactly 1 cycle from the acceptance edge (waitrequest low with read high) to readdatavalid.
- Write: committed to RAM at the acceptance edge.
- Throughput: 1 access/cycle total. Under continuous contention each port gets every other cycle.
- Back-to-back reads from alternating ports return in issue order, one per cycle, each tagged to the correct port.
- Combinational paths: pN_read/pN_write/pN_address → pN_waitrequest, and → mem_*.
- All outputs except pN_waitrequest and mem_* come from registers or from mem_readdata through a single mux.
- Reset values:
  - pN_readdatavalid = 0, err_status = 0.
  - pN_readdata = 0 (rd_oob reset to 1).
  - pN_waitrequest = 1 and mem_chipselect = 0 during reset.

## Test plan
- Port 0 writes 0xCAFEBABE to address 0x00010 (BE=0xF), then reads it → p0_waitrequest = 0 on both cycles; p0_readdatavalid high exactly 1 cycle after the read, with p0_readdata = 0xCAFEBABE; p1 sees no readdatavalid.
- Both ports read continuously from reset (p0 at addr 0x1, p1 at addr 0x2) → grants alternate p0, p1, p0, …; each readdatavalid appears 1 cycle after its grant on the correct port, with no losses.
- Port 1 writes BE=0x2 with data 0x0000AB00 over an existing 0x11223344, then reads → 0x1122AB44.
- Port 0 reads address 100000 → mem_chipselect stays 0; p0_readdatavalid is high 1 cycle later with readdata = 0; err_status = 2'b01 from the next cycle. err_clear pulsed in the same cycle as a new out-of-range access → flag remains set.
- Port 1 read accepted, then reset_n driven low on the next edge → no p1_readdatavalid; waitrequest = 1 on both ports while in reset; after release, the first tie goes to port 0.
